// File: rtl/bsg_regbank.sv
// bsg_regbank: per-channel CTRL/data register bank with end-of-transmission interrupt flags and registered reads
module bsg_regbank #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int N_CH      = 2,
  parameter int DATA_REGS = 2,
  parameter int BASE_ADDR = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sel,
  input  logic                             rw,
  input  logic [ADDR_W-1:0]                endereco,
  input  logic [DATA_W-1:0]                data_in,
  output logic [DATA_W-1:0]                data_out,
  output logic                             rd_valid,
  input  logic [N_CH*5-1:0]                ch_status,
  output logic [N_CH-1:0]                  tx_en,
  output logic [N_CH*DATA_REGS*DATA_W-1:0] ch_data,
  output logic [N_CH-1:0]                  irq,
  output logic                             irq_any
);
  localparam int ND = N_CH * DATA_REGS;
  logic [N_CH-1:0] tx_q, msk_q, flag_q, busy_q, armed, busy_now, ev, hit_c;
  logic [ND-1:0] hit_d;
  logic [DATA_W-1:0] dreg [ND];
  logic [DATA_W-1:0] ctrl_rd [N_CH];
  logic [DATA_W-1:0] rdata;
  logic wr, rd;
  assign wr = sel & ~rw;
  assign rd = sel & rw;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam logic [ADDR_W-1:0] CA = ADDR_W'(BASE_ADDR + c * (DATA_REGS + 1));
    assign hit_c[c] = endereco == CA;
    assign busy_now[c] = ch_status[c*5];
    assign ctrl_rd[c] = DATA_W'({ch_status[c*5+1 +: 4], ch_status[c*5], flag_q[c], msk_q[c], tx_q[c]});
    for (genvar r = 0; r < DATA_REGS; r++) begin : g_d
      localparam logic [ADDR_W-1:0] DA = ADDR_W'(BASE_ADDR + c * (DATA_REGS + 1) + r + 1);
      assign hit_d[c*DATA_REGS+r] = endereco == DA;
      assign ch_data[(c*DATA_REGS+r)*DATA_W +: DATA_W] = dreg[c*DATA_REGS+r];
    end
  end
  assign ev = busy_q & ~busy_now;
  assign tx_en = tx_q;
  assign irq = flag_q & msk_q;
  assign irq_any = |irq;
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CH; i++) rdata = hit_c[i] ? ctrl_rd[i] : rdata;
    for (int i = 0; i < ND; i++) rdata = hit_d[i] ? dreg[i] : rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= '0;
      msk_q <= '0;
      flag_q <= '0;
      busy_q <= '0;
      armed <= ~busy_now;
      for (int i = 0; i < ND; i++) dreg[i] <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      armed <= armed | ~busy_now;
      busy_q <= busy_now & armed;
      flag_q <= ev | (flag_q & ~({N_CH{wr & data_in[2]}} & hit_c));
      for (int i = 0; i < N_CH; i++) begin
        if (wr && hit_c[i]) begin
          tx_q[i] <= data_in[0];
          msk_q[i] <= data_in[1];
        end
      end
      for (int i = 0; i < ND; i++) if (wr && hit_d[i]) dreg[i] <= data_in;
      rd_valid <= rd;
      if (rd) data_out <= rdata;
    end
  end
endmodule

// File: tb/tb_bsg_regbank.sv
// tb_bsg_regbank: directed scoreboard bench for bsg_regbank
module tb_bsg_regbank;
  logic clk = 1'b0;
  logic rst, sel, rw;
  logic [7:0] endereco, data_in, data_out;
  logic rd_valid;
  logic [9:0] ch_status;
  logic [1:0] tx_en, irq;
  logic [31:0] ch_data;
  logic irq_any;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  bsg_regbank dut (
    .clk(clk), .rst(rst), .sel(sel), .rw(rw), .endereco(endereco), .data_in(data_in),
    .data_out(data_out), .rd_valid(rd_valid), .ch_status(ch_status), .tx_en(tx_en),
    .ch_data(ch_data), .irq(irq), .irq_any(irq_any)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid: data_out=%h, no read pending", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL read_data: got %h expected %h", data_out, e);
        end
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    sel = 1'b1; rw = 1'b0; endereco = a; data_in = d;
    @(negedge clk);
    sel = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    sel = 1'b1; rw = 1'b1; endereco = a; data_in = 8'h00;
    @(negedge clk);
    sel = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1; sel = 1'b0; rw = 1'b0; endereco = '0; data_in = '0; ch_status = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_tx_en", tx_en, 0);
    chk("reset_irq_any", irq_any, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_ch_data", ch_data, 0);
    for (int a = 10; a <= 15; a++) rd(8'(a), 8'h00);
    wr(8'd14, 8'hA5);
    wr(8'd13, 8'h07);
    chk("wr_tx_en", tx_en, 2'b10);
    chk("wr_ch_data", ch_data, 32'h00A5_0000);
    rd(8'd14, 8'hA5);
    rd(8'd13, 8'h03);
    ch_status[9:5] = 5'b10100;
    rd(8'd13, 8'hA3);
    ch_status[9:5] = 5'b00000;
    wr(8'd10, 8'h02);
    ch_status[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("eot_before_fall_irq", irq, 2'b00);
    ch_status[0] = 1'b0;
    @(negedge clk);
    chk("eot_irq", irq, 2'b01);
    chk("eot_irq_any", irq_any, 1);
    rd(8'd10, 8'h06);
    rd(8'd13, 8'h03);
    wr(8'd10, 8'h06);
    chk("w1c_irq", irq, 2'b00);
    rd(8'd10, 8'h02);
    ch_status[0] = 1'b1;
    repeat (2) @(negedge clk);
    ch_status[0] = 1'b0;
    wr(8'd10, 8'h06);
    chk("collision_irq", irq, 2'b01);
    rd(8'd10, 8'h06);
    wr(8'd10, 8'h06);
    wr(8'd10, 8'h00);
    ch_status[0] = 1'b1;
    @(negedge clk);
    ch_status[0] = 1'b0;
    @(negedge clk);
    chk("mask_irq_off", irq, 2'b00);
    chk("mask_irq_any_off", irq_any, 0);
    rd(8'd10, 8'h04);
    wr(8'd10, 8'h02);
    chk("mask_irq_on", irq, 2'b01);
    wr(8'd9, 8'hFF);
    wr(8'd16, 8'hFF);
    chk("unmapped_ch_data", ch_data, 32'h00A5_0000);
    chk("unmapped_tx_en", tx_en, 2'b10);
    rd(8'd9, 8'h00);
    rd(8'd16, 8'h00);
    ch_status[0] = 1'b1;
    rd(8'd10, 8'h0E);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_tx_en", tx_en, 0);
    chk("rst_mid_irq_any", irq_any, 0);
    chk("rst_mid_ch_data", ch_data, 0);
    wr(8'd10, 8'h02);
    repeat (2) @(negedge clk);
    ch_status[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_no_event_irq", irq, 2'b00);
    rd(8'd10, 8'h02);
    repeat (3) @(negedge clk);
    chk("pending_reads", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
